// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback path.
// Holds the register file geometry and the fixed requester slot numbers so
// the arbiter, the execute units and the benches agree on who is who.
package rf_wb_arbiter_pkg;

  // Register file geometry: 16 registers of 28 bits
  localparam int RF_DW    = 28;
  localparam int RF_AW    = 4;
  localparam int RF_NREGS = 1 << RF_AW;

  // Writeback requester slots; the slot number is the bit position in
  // req_valid / req_ready and the lane in the packed dest/data buses
  localparam int WB_ALU  = 0;
  localparam int WB_LSU  = 1;
  localparam int WB_MUL  = 2;
  localparam int WB_EXT  = 3;
  localparam int WB_NREQ = 4;

  // Width of a round-robin pointer over n requesters (at least one bit)
  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Combinational round-robin arbiter.
// Searches req starting at rr_ptr, wrapping modulo NREQ, and grants the
// first set bit. The pointer itself is owned by the parent so this block
// stays stateless.
// Ports:
//   req    - request vector, one bit per requester
//   rr_ptr - index that has highest priority this cycle
//   grant  - one-hot grant, zero when no request is set
import rf_wb_arbiter_pkg::*;

module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW  = ptrWidth(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant
);

  // Walk the requesters in priority order starting at rr_ptr; the first
  // set request wins and later ones are masked by the found flag
  always_comb begin
    int idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter and busy scoreboard in front of the register file.
// NREQ writeback sources share the single register file write port through
// a round-robin valid/ready arbiter; the winning write is registered for
// one cycle before it drives the register file. A per-register busy bit is
// set when an instruction issues and cleared when its write commits, and
// issue is stalled on RAW or WAW hazards against pending writes.
// Ports:
//   clk, rst      - clock and asynchronous active-high reset
//   req_valid     - per-requester write request
//   req_ready     - per-requester grant, one-hot or zero
//   req_dest      - packed destination indices, requester i at [i*AW +: AW]
//   req_data      - packed write data, requester i at [i*DW +: DW]
//   rf_wen        - register file write enable
//   rf_dest_sel   - register file write index
//   rf_data_in    - register file write data
//   iss_valid     - issue stage presents an instruction
//   iss_dest      - destination of the issuing instruction
//   iss_rs0/rs1   - source indices of the issuing instruction
//   iss_stall     - issue must hold this cycle
//   busy_vec      - scoreboard, bit r set while a write to r is pending
import rf_wb_arbiter_pkg::*;

module rf_wb_arbiter #(
  parameter int NREQ = WB_NREQ,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_dest,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_dest_sel,
  output logic [DW-1:0]        rf_data_in,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_dest,
  input  logic [AW-1:0]        iss_rs0,
  input  logic [AW-1:0]        iss_rs1,
  output logic                 iss_stall,
  output logic [(1<<AW)-1:0]   busy_vec
);

  localparam int PW    = ptrWidth(NREQ);
  localparam int NREGS = 1 << AW;

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    rr_ptr_nxt;
  logic [NREQ-1:0]  grant;
  logic [PW-1:0]    gnt_idx;
  logic [AW-1:0]    sel_dest;
  logic [DW-1:0]    sel_data;
  logic             xfer;
  logic             iss_set;
  logic [NREGS-1:0] busy_nxt;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  // The grant only ever selects a valid requester, so it doubles as the
  // ready vector and any set bit means a transfer happens this cycle
  assign req_ready = grant;
  assign xfer      = |grant;

  // Steer the granted requester's lane onto the write path and remember
  // its index so the pointer can move just past it
  always_comb begin
    gnt_idx  = '0;
    sel_dest = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gnt_idx  = PW'(i);
        sel_dest = req_dest[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
    rr_ptr_nxt = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
  end

  // Output stage: an accepted write appears on the register file port the
  // next cycle. Writes to register 0 still use up their grant but never
  // raise rf_wen. Idle cycles drop rf_wen and keep index/data as they were.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      rf_wen      <= 1'b0;
      rf_dest_sel <= '0;
      rf_data_in  <= '0;
    end else if (xfer) begin
      rr_ptr      <= rr_ptr_nxt;
      rf_wen      <= (sel_dest != '0);
      rf_dest_sel <= sel_dest;
      rf_data_in  <= sel_data;
    end else begin
      rf_wen      <= 1'b0;
    end
  end

  // A register stays busy through the cycle its write is on the port, so
  // the same comparison covers both pending and in-flight writes
  always_comb begin
    iss_stall = iss_valid &
                (((iss_rs0  != '0) & busy_vec[iss_rs0])  |
                 ((iss_rs1  != '0) & busy_vec[iss_rs1])  |
                 ((iss_dest != '0) & busy_vec[iss_dest]));
  end

  assign iss_set = iss_valid & ~iss_stall & (iss_dest != '0);

  // Scoreboard update: clear on commit first, then apply the issue set so
  // that a newer pending write to the same register survives the collision
  always_comb begin
    busy_nxt = busy_vec;
    if (rf_wen) begin
      busy_nxt[rf_dest_sel] = 1'b0;
    end
    if (iss_set) begin
      busy_nxt[iss_dest] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_nxt;
    end
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between NREQ writeback requesters (ALU, load unit, etc.) using a round-robin valid/ready arbiter.
- Drives the register file's wen / dest_sel / data_in through a one-cycle registered stage.
- Holds a per-register busy scoreboard, set at issue and cleared at write commit, and raises an issue stall on RAW and WAW hazards.
- Sits between thread issue/execute and the 16x28 register file.

Parameters:
- NREQ, 4, number of writeback requesters (2..8).
- DW, 28, register data width.
- AW, 4, register index width; 2^AW registers.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  per-requester write request.
- req_ready  out  NREQ  per-requester grant, one-hot or zero.
- req_dest  in  NREQ*AW  packed destination index; requester i at [i*AW +: AW].
- req_data  in  NREQ*DW  packed write data; requester i at [i*DW +: DW].
- rf_wen  out  1  register file write enable.
- rf_dest_sel  out  AW  register file write index.
- rf_data_in  out  DW  register file write data.
- iss_valid  in  1  issue stage presents an instruction.
- iss_dest  in  AW  destination of the issuing instruction.
- iss_rs0  in  AW  source 0 index.
- iss_rs1  in  AW  source 1 index.
- iss_stall  out  1  issue must hold; combinational.
- busy_vec  out  2^AW  scoreboard, bit r = write to r pending.

Behaviour:
- Reset (async, rst=1): rr_ptr=0, busy_vec=0, rf_wen=0, rf_dest_sel=0, rf_data_in=0.
- Arbitration (combinational): grant = first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready = onehot(grant) when any request is valid, else 0.
  - req_ready never depends on its own requester's data.
- Transfer when req_valid[i] & req_ready[i]. At that edge:
  - rr_ptr <= (i+1) mod NREQ.
  - rf_wen <= (req_dest_i != 0).
  - rf_dest_sel <= req_dest_i.
  - rf_data_in <= req_data_i.
- Latency: request accepted in cycle N, register file write presented in N+1, committed at the end of N+1.
- Idle cycle (no valid request): rf_wen <= 0; rf_dest_sel and rf_data_in hold their last values; rr_ptr holds.
- Requester contract: holds valid, dest and data stable until ready. The arbiter accepts one write per cycle, so throughput is 1 per cycle.
- Destination 0: the request is accepted and consumes its grant, but rf_wen stays 0 and the scoreboard is untouched.
- Scoreboard set: iss_valid & ~iss_stall & iss_dest!=0 sets busy[iss_dest] at the edge.
- Scoreboard clear: rf_wen=1 clears busy[rf_dest_sel] at the same edge the register file commits. A reader in the following cycle therefore sees the new value.
- Set and clear of the same register in one cycle: set wins, since it represents a newer pending write.
- busy[0] is constant 0.
- iss_stall = iss_valid & ((iss_rs0!=0 & busy[iss_rs0]) | (iss_rs1!=0 & busy[iss_rs1]) | (iss_dest!=0 & busy[iss_dest])).
  - The dest term is the WAW check.
  - A register being written this cycle (rf_wen=1) is still busy, so the issue stalls for exactly that cycle.
- Reset mid-operation: all pending writes are dropped, the output write is cancelled (rf_wen=0 immediately), and the scoreboard clears.
- A write to a non-busy register (no matching issue) is legal and simply commits.

Decomposition:
- Shared package:
  - RF_DW=28, RF_AW=4, RF_NREGS=16.
  - Requester index constants (WB_ALU=0, WB_LSU=1, WB_MUL=2, WB_EXT=3).
- One sub-module: rr_arbiter.
  - Parameter NREQ.
  - Inputs: req vector and rr_ptr.
  - Output: one-hot grant.
  - Purely combinational, with pointer state in the parent.
- Scoreboard and output stage live in rf_wb_arbiter.

Test Plan:
1. After reset, all four requesters valid every cycle with dest 1..4, data 0xA1..0xA4 -> grants in order 0,1,2,3,0; rf_wen=1 each following cycle with matching dest/data; rr_ptr wraps 3->0.
2. Issue dest=5 (no stall), then issue rs0=5 next cycle -> iss_stall=1 until requester 1 writes dest 5 data 0x0ABCDEF. Stall persists through the rf_wen cycle and drops the cycle after; busy_vec[5] goes 1 -> 0.
3. Requester 2 sends dest 0 data 0xFFFFFFF -> req_ready[2]=1; rf_wen stays 0 next cycle; busy_vec unchanged; iss_rs0=0 never stalls.
4. Same cycle: rf_wen=1 with dest 7 (clearing) and an issue with dest 7 is rejected by the WAW stall. Force the set/clear collision by issuing dest 7 when busy[7]=0 while an unrelated pending write to 7 commits -> busy[7]=1 after the edge (set wins).
5. Only requester 3 valid while rr_ptr=0 -> grant to 3 in the same cycle; rr_ptr becomes 0; then requesters 0 and 3 both valid -> 0 granted first.
6. Assert rst while rf_wen=1 and busy_vec=0x00A4 -> rf_wen, busy_vec and rr_ptr are 0 asynchronously, before the next clock edge.
